// File: rtl/game_pkg.sv
// Shared definitions for the object-slot scheduler: slot word layout, FSM
// encoding and default geometry constants.
package game_pkg;

  localparam int SCREEN_WIDTH_DEF = 1024;
  localparam int CHAR_WIDTH_DEF   = 20;
  localparam int CHAR_HEIGHT_DEF  = 20;
  localparam int OBJ_HEIGHT_DEF   = 20;
  localparam int Y_BASE_DEF       = 220;
  localparam int NUM_SLOTS_DEF    = 5;

  localparam int SLOT_W = 26;

  // Packed layout: [25:23] frame, [22:21] identity, [20:10] x, [9:0] y.
  // An all-zero word means the slot is empty.
  typedef struct packed {
    logic [2:0]  frame;
    logic [1:0]  id;
    logic [10:0] x;
    logic [9:0]  y;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_SPAWN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/obj_slot_update.sv
// Single-slot frame update: collision against the player, leftward scroll,
// off-screen removal and frame-field advance. Purely combinational.
module obj_slot_update
  import game_pkg::*;
#(
  parameter int CHAR_WIDTH  = CHAR_WIDTH_DEF,
  parameter int CHAR_HEIGHT = CHAR_HEIGHT_DEF,
  parameter int OBJ_HEIGHT  = OBJ_HEIGHT_DEF
) (
  input  logic [SLOT_W-1:0] slot_in,
  input  logic [3:0]        speed,
  input  logic [9:0]        p_vpos,
  input  logic              frame_adv,
  output logic [SLOT_W-1:0] slot_out,
  output logic              hit
);

  slot_t       cur;
  slot_t       nxt;
  logic        occupied;
  logic [10:0] y_ext;
  logic [10:0] speed_ext;
  logic [10:0] upper;
  logic [10:0] lower;

  always_comb begin
    cur       = slot_t'(slot_in);
    occupied  = (slot_in != '0);
    y_ext     = {1'b0, cur.y};
    speed_ext = {7'd0, speed};
    upper     = {1'b0, p_vpos} + 11'(CHAR_HEIGHT);
    // Lower bound clamps at zero so a player near the top never wraps.
    lower     = (p_vpos < 10'(OBJ_HEIGHT)) ? 11'd0 : ({1'b0, p_vpos} - 11'(OBJ_HEIGHT));
    hit       = occupied && (cur.x < 11'(CHAR_WIDTH)) && (y_ext < upper) && (y_ext > lower);

    // NOTE: nxt gets a full default before any branch so no path leaves it unassigned (no latch).
    nxt = '0;
    if (occupied && !hit && (cur.x > speed_ext)) begin
      nxt       = cur;
      nxt.x     = cur.x - speed_ext;
      nxt.frame = cur.frame + 3'(frame_adv);
    end
    slot_out = nxt;
  end

endmodule

// File: rtl/obj_slot_scheduler.sv
// Per-frame object scheduler: walks the slot table one entry per cycle through
// a shared update datapath, then optionally spawns one new object.
module obj_slot_scheduler
  import game_pkg::*;
#(
  parameter int SCREEN_WIDTH = SCREEN_WIDTH_DEF,
  parameter int CHAR_WIDTH   = CHAR_WIDTH_DEF,
  parameter int CHAR_HEIGHT  = CHAR_HEIGHT_DEF,
  parameter int OBJ_HEIGHT   = OBJ_HEIGHT_DEF,
  parameter int Y_BASE       = Y_BASE_DEF,
  parameter int NUM_SLOTS    = NUM_SLOTS_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic                play_en,
  input  logic [3:0]          speed,
  input  logic [9:0]          p_vpos,
  input  logic                spawn_req,
  input  logic                spawn_id,
  input  logic [7:0]          spawn_y,
  output logic                spawn_ack,
  output logic [SLOT_W-1:0]   p_obj1,
  output logic [SLOT_W-1:0]   p_obj2,
  output logic [SLOT_W-1:0]   p_obj3,
  output logic [SLOT_W-1:0]   p_obj4,
  output logic [SLOT_W-1:0]   p_obj5,
  output logic [7:0]          score,
  output logic                busy,
  output logic                done
);

  localparam int IDX_W = $clog2(NUM_SLOTS + 1);

  state_t            state;
  logic [SLOT_W-1:0] slots [NUM_SLOTS];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  free_idx;
  logic              free_found;
  logic [2:0]        frame_cnt;
  logic              frame_adv;
  logic [3:0]        speed_q;
  logic [9:0]        p_vpos_q;
  logic [SLOT_W-1:0] cur_slot;
  logic [SLOT_W-1:0] upd_out;
  logic              upd_hit;
  logic [SLOT_W-1:0] spawn_word;

  always_comb begin
    cur_slot = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (idx == IDX_W'(i)) cur_slot = slots[i];
  end

  assign spawn_word = {3'b000, 1'b0, spawn_id, 11'(SCREEN_WIDTH), 10'(Y_BASE) + {2'b00, spawn_y}};

  obj_slot_update #(
    .CHAR_WIDTH  (CHAR_WIDTH),
    .CHAR_HEIGHT (CHAR_HEIGHT),
    .OBJ_HEIGHT  (OBJ_HEIGHT)
  ) u_update (
    .slot_in   (cur_slot),
    .speed     (speed_q),
    .p_vpos    (p_vpos_q),
    .frame_adv (frame_adv),
    .slot_out  (upd_out),
    .hit       (upd_hit)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      // NOTE: the slot table is reset because all-zero is the architectural "empty" encoding.
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      idx        <= '0;
      free_idx   <= '0;
      free_found <= 1'b0;
      frame_cnt  <= 3'd0;
      frame_adv  <= 1'b0;
      speed_q    <= 4'd0;
      p_vpos_q   <= 10'd0;
      score      <= 8'd0;
      spawn_ack  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      spawn_ack <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (frame_start && play_en) begin
            state      <= ST_SCAN;
            busy       <= 1'b1;
            speed_q    <= speed;
            p_vpos_q   <= p_vpos;
            frame_adv  <= (frame_cnt == 3'd0);
            frame_cnt  <= frame_cnt + 3'd1;
            idx        <= '0;
            free_found <= 1'b0;
          end
        end
        ST_SCAN: begin
          // The cycle after the last slot is the spawn decision; ack shows during SPAWN.
          if (idx == IDX_W'(NUM_SLOTS)) begin
            if (spawn_req && free_found) begin
              for (int i = 0; i < NUM_SLOTS; i++)
                if (free_idx == IDX_W'(i)) slots[i] <= spawn_word;
              spawn_ack <= 1'b1;
            end
            state <= ST_SPAWN;
          end else begin
            for (int i = 0; i < NUM_SLOTS; i++)
              if (idx == IDX_W'(i)) slots[i] <= upd_out;
            if (upd_hit && (score != 8'hFF)) score <= score + 8'd1;
            if ((cur_slot == '0) && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
            idx <= idx + IDX_W'(1);
          end
        end
        ST_SPAWN: begin
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign p_obj1 = slots[0];
  assign p_obj2 = slots[1];
  assign p_obj3 = slots[2];
  assign p_obj4 = slots[3];
  assign p_obj5 = slots[4];

endmodule

// File: tb/tb_obj_slot_scheduler.sv
// Self-checking bench: a frame-level reference model predicts every output
// each cycle; directed frames pin the model with hand-computed literals.
module tb_obj_slot_scheduler;

  logic        clock;
  logic        reset_n;
  logic        frame_start;
  logic        play_en;
  logic [3:0]  speed;
  logic [9:0]  p_vpos;
  logic        spawn_req;
  logic        spawn_id;
  logic [7:0]  spawn_y;
  logic        spawn_ack;
  logic [25:0] p_obj1, p_obj2, p_obj3, p_obj4, p_obj5;
  logic [7:0]  score;
  logic        busy;
  logic        done;

  obj_slot_scheduler dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .play_en     (play_en),
    .speed       (speed),
    .p_vpos      (p_vpos),
    .spawn_req   (spawn_req),
    .spawn_id    (spawn_id),
    .spawn_y     (spawn_y),
    .spawn_ack   (spawn_ack),
    .p_obj1      (p_obj1),
    .p_obj2      (p_obj2),
    .p_obj3      (p_obj3),
    .p_obj4      (p_obj4),
    .p_obj5      (p_obj5),
    .score       (score),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [25:0] e_slot     [5];
  logic [25:0] plan_slot  [5];
  int          plan_score [5];
  int          plan_hit   [5];
  int          e_score, m_cnt, phase, free_i, m_hits;
  int          e_busy, e_done, e_ack;

  // Whole-frame outcome from the rules, computed at frame acceptance.
  task automatic plan_frame(input int sp, input int pv);
    int w, x, y, f, idb, lo, s, adv;
    adv    = (m_cnt == 0) ? 1 : 0;
    m_cnt  = (m_cnt + 1) % 8;
    free_i = -1;
    s      = e_score;
    lo     = (pv < 20) ? 0 : pv - 20;
    for (int i = 0; i < 5; i++) begin
      plan_hit[i]  = 0;
      plan_slot[i] = '0;
      w = int'(e_slot[i]);
      if (w == 0) begin
        if (free_i < 0) free_i = i;
      end else begin
        x   = (w >> 10) & 2047;
        y   = w & 1023;
        f   = (w >> 23) & 7;
        idb = (w >> 21) & 3;
        if (x < 20 && y < pv + 20 && y > lo) begin
          plan_hit[i] = 1;
          if (s < 255) s++;
        end else if (x > sp) begin
          plan_slot[i] = 26'((((f + adv) % 8) << 23) | (idb << 21) | ((x - sp) << 10) | y);
        end
      end
      plan_score[i] = s;
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 5; i++) e_slot[i] = '0;
      e_score = 0; m_cnt = 0; phase = -1; m_hits = 0;
      e_busy = 0; e_done = 0; e_ack = 0;
    end else if (phase < 0) begin
      if (frame_start && play_en) begin
        plan_frame(int'(speed), int'(p_vpos));
        phase  = 0;
        e_busy = 1;
      end
    end else begin
      phase++;
      if (phase <= 5) begin
        e_slot[phase-1] = plan_slot[phase-1];
        e_score         = plan_score[phase-1];
        m_hits          = m_hits + plan_hit[phase-1];
      end else if (phase == 6) begin
        if (spawn_req && free_i >= 0) begin
          e_slot[free_i] = 26'((int'(spawn_id) << 21) | (1024 << 10) | (220 + int'(spawn_y)));
          e_ack = 1;
        end
      end else if (phase == 7) begin
        e_ack  = 0;
        e_done = 1;
      end else begin
        e_done = 0;
        e_busy = 0;
        phase  = -1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      check("p_obj1", p_obj1, e_slot[0]);
      check("p_obj2", p_obj2, e_slot[1]);
      check("p_obj3", p_obj3, e_slot[2]);
      check("p_obj4", p_obj4, e_slot[3]);
      check("p_obj5", p_obj5, e_slot[4]);
      check("score", score, e_score);
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("spawn_ack", spawn_ack, e_ack);
    end
  end

  // ---------------- stimulus ----------------
  int r_ack_at, r_done_at, r_ack_n, r_done_n;

  task automatic run_frame(input int sp, input int pv, input bit req, input bit id,
                           input int sy, input bit pe, input bit hold, input bit drop);
    @(posedge clock); #2;
    frame_start = 1'b1; play_en = pe; speed = 4'(sp); p_vpos = 10'(pv);
    spawn_req = req; spawn_id = id; spawn_y = 8'(sy);
    @(posedge clock); #2;
    // Scramble speed/p_vpos after acceptance: the frame must use captured values.
    frame_start = hold; speed = 4'($urandom); p_vpos = 10'($urandom);
    if (drop) play_en = 1'b0;
    r_ack_at = -1; r_done_at = -1; r_ack_n = 0; r_done_n = 0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clock);
      if (spawn_ack) begin r_ack_at = j; r_ack_n++; end
      if (done) begin r_done_at = j; r_done_n++; end
    end
    frame_start = 1'b0;
  endtask

  initial begin
    int frames;
    reset_n = 1'b0; frame_start = 1'b0; play_en = 1'b0; speed = '0; p_vpos = '0;
    spawn_req = 1'b0; spawn_id = 1'b0; spawn_y = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_score", score, 0);
    check("rst_objs", p_obj1 | p_obj2 | p_obj3 | p_obj4 | p_obj5, 0);
    check("rst_done_ack", {done, spawn_ack}, 0);
    @(posedge clock); #2 reset_n = 1'b1;

    run_frame(3, 0, 1, 1, 10, 0, 0, 0);
    check("pe0_ignored", r_done_n, 0);

    run_frame(3, 0, 1, 1, 10, 1, 0, 0);
    check("ack_at_k6", r_ack_at, 6);
    check("done_at_k7", r_done_at, 7);
    check("first_spawn", p_obj1, 32'h3000E6);
    run_frame(3, 0, 1, 1, 10, 1, 0, 0);
    run_frame(3, 0, 1, 1, 10, 1, 0, 0);
    check("slot3_spawn", p_obj3, 32'h3000E6);
    check("slot3_ack_at", r_ack_at, 6);
    run_frame(3, 0, 1, 0, 5, 1, 0, 0);
    run_frame(3, 0, 1, 0, 5, 1, 0, 0);
    run_frame(3, 0, 1, 1, 5, 1, 0, 0);
    check("full_no_ack", r_ack_n, 0);
    run_frame(3, 0, 0, 0, 0, 1, 1, 0);
    check("busy_fs_ignored", r_done_n, 1);
    run_frame(3, 0, 0, 0, 0, 1, 0, 1);
    check("pe_drop_completes", r_done_at, 7);
    run_frame(3, 0, 0, 0, 0, 1, 0, 0);
    check("move_frame_adv", p_obj1, 32'hAFA0E6);

    // Reset in the middle of a frame.
    @(posedge clock); #2 frame_start = 1'b1; play_en = 1'b1;
    @(posedge clock); #2 frame_start = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_objs", p_obj1 | p_obj2 | p_obj3 | p_obj4 | p_obj5, 0);
    check("midrst_score", score, 0);
    check("midrst_flags", {busy, done, spawn_ack}, 0);
    @(posedge clock); #2 reset_n = 1'b1;

    // Off-screen removal: walk one object down to x=3, then scroll by 3.
    run_frame(15, 900, 1, 0, 10, 1, 0, 0);
    check("spawn_after_reset", p_obj1, 32'h1000E6);
    for (int i = 0; i < 68; i++) run_frame(15, 900, 0, 0, 0, 1, 0, 0);
    run_frame(1, 900, 0, 0, 0, 1, 0, 0);
    check("x_at_3", p_obj1, 32'h0000CE6);
    run_frame(3, 900, 0, 0, 0, 1, 0, 0);
    check("offscreen_clear", p_obj1, 0);
    check("offscreen_no_score", score, 0);

    // Collision with all slots full: freed slot not reused the same frame.
    for (int i = 0; i < 5; i++) run_frame(15, 300, 1, 0, 85, 1, 0, 0);
    for (int i = 0; i < 63; i++) run_frame(15, 300, 0, 0, 0, 1, 0, 0);
    check("x_at_19", p_obj1[20:10], 19);
    run_frame(15, 300, 1, 0, 85, 1, 0, 0);
    check("freed_no_ack", r_ack_n, 0);
    check("collide_clear", p_obj1, 0);
    check("collide_score", score, 1);
    run_frame(15, 300, 1, 0, 85, 1, 0, 0);
    check("respawn_ack", r_ack_at, 6);

    // Randomised farming until the score saturates.
    frames = 0;
    while (m_hits < 258 && frames < 6000) begin
      run_frame(12 + int'($urandom % 4), 295 + int'($urandom % 11), ($urandom % 10) != 0,
                1'($urandom), 70 + int'($urandom % 21), ($urandom % 20) != 0,
                ($urandom % 10) == 0, ($urandom % 8) == 0);
      frames++;
    end
    check("farm_budget", (m_hits >= 258) ? 1 : 0, 1);
    check("score_sat", score, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obj_slot_scheduler.md
OBJ_SLOT_SCHEDULER -- requirements
Module: obj_slot_scheduler

Interface
REQ-001 SHALL have parameters: SCREEN_WIDTH=1024 (spawn x); CHAR_WIDTH=20 (player hit width); CHAR_HEIGHT=20 (player height); OBJ_HEIGHT=20 (object height); Y_BASE=220 (spawn y offset); NUM_SLOTS=5 (object slots).
REQ-002 SHALL have ports:
- clock  in  1  system clock; one clock domain only.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse per video frame.
- play_en  in  1  game in PLAY state.
- speed  in  4  scroll pixels per frame.
- p_vpos  in  10  player vertical position.
- spawn_req  in  1  level request to create an object.
- spawn_id  in  1  identity bit for the new object.
- spawn_y  in  8  vertical offset for the new object.
- spawn_ack  out  1  one-cycle pulse: request granted.
- p_obj1..p_obj5  out  26 each  slot words: [25:23] frame, [22:21] identity, [20:10] x, [9:0] y; all-zero = empty.
- score  out  8  collected-object count.
- busy  out  1  high from SCAN through DONE.
- done  out  1  one-cycle pulse when frame update completes.

Function
REQ-003 SHALL implement FSM states IDLE, SCAN, SPAWN, DONE; reset state IDLE.
REQ-004 IDLE -> SCAN when frame_start=1 and play_en=1 at a clock edge (edge k); speed and p_vpos captured at edge k and held for the frame.
REQ-005 frame_start while not IDLE, or while play_en=0, SHALL be ignored; slots and score stay frozen.
REQ-006 SCAN SHALL process one slot per cycle, index 0..4 in edges k+1..k+5, through one shared update datapath; SPAWN at k+6; DONE at k+7 (done=1); IDLE at k+8.
REQ-007 A 3-bit frame counter SHALL increment, wrapping 7->0, at each accepted frame_start. The frame field of each occupied slot SHALL increment modulo 8 when the pre-increment counter value is 0.
REQ-008 Occupied slot, collision: x < CHAR_WIDTH and y < p_vpos+CHAR_HEIGHT and y > p_vpos-OBJ_HEIGHT. Compare using pre-update values in 11-bit arithmetic. If p_vpos < OBJ_HEIGHT, the lower bound is 0 (no underflow).
REQ-009 On collision: slot cleared to 0; score incremented, saturating at 255. Collision overrides move.
REQ-010 Occupied slot, no collision: if x > speed, then x <= x - speed; otherwise the slot is cleared with no score change. x == speed clears; speed=0 leaves x unchanged.
REQ-011 During SCAN the block SHALL record the lowest-index slot that was empty at the start of its scan cycle. Slots freed during this frame are not reusable until the next frame.
REQ-012 In SPAWN, if spawn_req=1 and a free slot was recorded, the slot SHALL be written {3'b000, 1'b0, spawn_id, SCREEN_WIDTH[10:0], Y_BASE+spawn_y}, and spawn_ack=1 for that cycle.
REQ-013 If there is no free slot or spawn_req=0, there SHALL be no write and no ack. The request is not queued; the requester retries on the next frame.
REQ-014 The block SHALL perform at most one spawn per frame.
REQ-015 busy SHALL be 1 in SCAN, SPAWN and DONE, and 0 in IDLE.
REQ-016 play_en falling mid-frame SHALL NOT abort the sequence; the current frame completes.

Reset
REQ-017 reset_n=0 SHALL asynchronously force: state IDLE; all p_obj = 0; score = 0; frame counter = 0; slot index = 0; spawn_ack, busy, done = 0.
REQ-018 Reset asserted mid-frame SHALL discard partial updates; the first accepted frame_start after release starts from slot 0.

Structure
REQ-019 Slot field bit positions, the FSM state encoding and the default parameter constants SHALL live in the shared package game_pkg.
REQ-020 The single-slot move/collide/frame-advance datapath SHALL be the combinational sub-module obj_slot_update, instantiated once and time-multiplexed across slots.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Move: slot1 x=256, speed=3, no collision -> after done, x=253; frame field +1 only when counter was 0.
- Collision: p_vpos=300, slot2 x=10 y=305 -> slot2=0, score +1.
- Score saturation: score=255 plus one collision -> score stays 255.
- Off-screen: x=3, speed=3 -> slot cleared, score unchanged.
- Spawn and freeing:
  - Slots 1,2 full, slot3 empty, spawn_req=1, spawn_id=1, spawn_y=10 -> slot3 = {000,01,1024,230}, spawn_ack pulses at k+6.
  - All slots full, one freed by collision this frame -> no ack.
- Sequencing:
  - frame_start during busy -> ignored.
  - reset_n low at k+3 -> all outputs 0 immediately.
  - play_en=0 -> frame_start ignored.
  - done pulses exactly at k+7.
